// File: rtl/mxu_sequencer_pkg.sv
// rtl/mxu_sequencer_pkg.sv - shared types, constants and latency helper for the MXU sequencer
package mxu_sequencer_pkg;

   localparam int LOG_ALLOWED_PRECISIONS = 2;
   localparam int CNT_W_DEFAULT          = 8;

   typedef logic [LOG_ALLOWED_PRECISIONS-1:0] precision_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } seq_state_t;

   // Input skew across K columns, the core itself, then output deskew across M rows.
   function automatic int calc_l_tot(input int m, input int k, input int core_lat);
      return (k - 1) + core_lat + (m - 1);
   endfunction

endpackage

// File: rtl/mxu_sequencer_if.sv
// rtl/mxu_sequencer_if.sv - job request, vector stream and MXU control signals of the sequencer
interface mxu_sequencer_if #(
   parameter int CNT_W = mxu_sequencer_pkg::CNT_W_DEFAULT
);

   logic                           start;
   logic [CNT_W-1:0]               num_vectors;
   mxu_sequencer_pkg::precision_t  cfg_data_type;
   logic [1:0]                     cfg_fp_unit;

   logic                           in_valid;
   logic                           in_ready;
   logic                           out_valid;
   logic                           out_last;

   logic                           busy;
   logic                           done;

   logic                           mxu_enable;
   logic                           mxu_enable_in_ff;
   logic                           mxu_enable_chain;
   logic                           mxu_enable_out_ff;
   mxu_sequencer_pkg::precision_t  mxu_data_type;
   logic [1:0]                     mxu_enable_fp_unit;

   modport master (
      output start, num_vectors, cfg_data_type, cfg_fp_unit, in_valid,
      input  in_ready, out_valid, out_last, busy, done,
      input  mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff,
      input  mxu_data_type, mxu_enable_fp_unit
   );

   modport slave (
      input  start, num_vectors, cfg_data_type, cfg_fp_unit, in_valid,
      output in_ready, out_valid, out_last, busy, done,
      output mxu_enable, mxu_enable_in_ff, mxu_enable_chain, mxu_enable_out_ff,
      output mxu_data_type, mxu_enable_fp_unit
   );

endinterface

// File: rtl/mxu_sequencer_valid_tracker.sv
// rtl/mxu_sequencer_valid_tracker.sv - valid-bit shift register that mirrors vectors moving through the MXU
module mxu_valid_tracker #(
   parameter int DEPTH = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic advance,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr_q;
   logic [DEPTH-1:0] sr_d;

   // Shifts only with the array so a stalled pipeline keeps its in-flight markers in place.
   always_comb begin
      sr_d = sr_q;
      if (advance) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            sr_d[i] = sr_q[i-1];
         end
         sr_d[0] = din;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/mxu_sequencer.sv
// rtl/mxu_sequencer.sv - job sequencer: feeds vectors into the MXU, gates its pipeline and flags deskewed outputs
module mxu_sequencer
   import mxu_sequencer_pkg::*;
#(
   parameter int M        = 3,
   parameter int K        = 3,
   parameter int CORE_LAT = 1,
   parameter int CNT_W    = CNT_W_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   mxu_sequencer_if.slave bus
);

   localparam int               L_TOT   = calc_l_tot(M, K, CORE_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   seq_state_t       state_q;
   seq_state_t       state_d;

   logic [CNT_W-1:0] target_q;
   logic [CNT_W-1:0] target_d;
   logic [CNT_W-1:0] acc_cnt_q;
   logic [CNT_W-1:0] acc_cnt_d;
   logic [CNT_W-1:0] emit_cnt_q;
   logic [CNT_W-1:0] emit_cnt_d;
   precision_t       dtype_q;
   precision_t       dtype_d;
   logic [1:0]       fp_unit_q;
   logic [1:0]       fp_unit_d;

   logic             start_job;
   logic             in_ready_c;
   logic             advance;
   logic             busy_c;
   logic             done_c;
   logic             accept;
   logic             last_accept;
   logic             tracker_out;
   logic             emit;
   logic             last_emit;

   assign start_job   = (state_q == ST_IDLE) && bus.start;
   assign accept      = in_ready_c && bus.in_valid;
   assign last_accept = accept && (acc_cnt_q == (target_q - CNT_ONE));
   assign emit        = tracker_out && advance;
   assign last_emit   = emit && (emit_cnt_q == (target_q - CNT_ONE));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = (bus.num_vectors == '0) ? ST_DONE : ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (last_accept) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (last_emit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // While streaming the array only moves when a new vector enters; draining clocks it freely.
   always_comb begin
      in_ready_c = 1'b0;
      advance    = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            busy_c = 1'b0;
         end
         ST_STREAM: begin
            in_ready_c = 1'b1;
            advance    = bus.in_valid;
            busy_c     = 1'b1;
         end
         ST_DRAIN: begin
            advance = 1'b1;
            busy_c  = 1'b1;
         end
         ST_DONE: begin
            busy_c = 1'b1;
            done_c = 1'b1;
         end
         default: begin
            busy_c = 1'b0;
         end
      endcase
   end

   // Config is captured once per job and held until the next accepted start.
   always_comb begin
      target_d   = target_q;
      acc_cnt_d  = acc_cnt_q;
      emit_cnt_d = emit_cnt_q;
      dtype_d    = dtype_q;
      fp_unit_d  = fp_unit_q;
      if (start_job) begin
         target_d   = bus.num_vectors;
         acc_cnt_d  = '0;
         emit_cnt_d = '0;
         dtype_d    = bus.cfg_data_type;
         fp_unit_d  = bus.cfg_fp_unit;
      end else begin
         if (accept) begin
            acc_cnt_d = acc_cnt_q + CNT_ONE;
         end
         if (emit) begin
            emit_cnt_d = emit_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         target_q   <= '0;
         acc_cnt_q  <= '0;
         emit_cnt_q <= '0;
         dtype_q    <= '0;
         fp_unit_q  <= '0;
      end else begin
         target_q   <= target_d;
         acc_cnt_q  <= acc_cnt_d;
         emit_cnt_q <= emit_cnt_d;
         dtype_q    <= dtype_d;
         fp_unit_q  <= fp_unit_d;
      end
   end

   mxu_valid_tracker #(
      .DEPTH (L_TOT)
   ) u_valid_tracker (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .din     (accept),
      .dout    (tracker_out)
   );

   assign bus.in_ready           = in_ready_c;
   assign bus.out_valid          = emit;
   assign bus.out_last           = last_emit;
   assign bus.busy               = busy_c;
   assign bus.done               = done_c;
   assign bus.mxu_enable         = advance;
   assign bus.mxu_enable_in_ff   = advance;
   assign bus.mxu_enable_chain   = advance;
   assign bus.mxu_enable_out_ff  = advance;
   assign bus.mxu_data_type      = dtype_q;
   assign bus.mxu_enable_fp_unit = fp_unit_q;

endmodule

// File: tb/tb_mxu_sequencer.sv
// tb/tb_mxu_sequencer.sv - self-checking bench for mxu_sequencer
module tb_mxu_sequencer;
   import mxu_sequencer_pkg::*;

   // 3x3 array with a single-cycle core
   localparam int LT = 5;

   typedef struct {
      int         n;
      logic [1:0] dt;
      logic [1:0] fp;
      int         mode;
      bit         poke;
      int         exp_ov;
      int         exp_first;
      int         exp_last;
      int         exp_done;
      int         exp_en;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   mxu_sequencer_if #(.CNT_W(8)) bus  ();
   mxu_sequencer_if #(.CNT_W(4)) bus4 ();

   mxu_sequencer #(.M(3), .K(3), .CORE_LAT(1), .CNT_W(8)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   mxu_sequencer #(.M(3), .K(3), .CORE_LAT(1), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] outs_main();
      return 32'({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done,
                  bus.mxu_enable, bus.mxu_enable_in_ff, bus.mxu_enable_chain, bus.mxu_enable_out_ff,
                  bus.mxu_data_type, bus.mxu_enable_fp_unit});
   endfunction

   function automatic logic [31:0] outs_cnt4();
      return 32'({bus4.in_ready, bus4.out_valid, bus4.out_last, bus4.busy, bus4.done,
                  bus4.mxu_enable, bus4.mxu_enable_in_ff, bus4.mxu_enable_chain, bus4.mxu_enable_out_ff,
                  bus4.mxu_data_type, bus4.mxu_enable_fp_unit});
   endfunction

   // Reference: a vector accepted at advance index a leaves the array at advance index a+LT.
   task automatic run_job(input int n, input logic [1:0] dt, input logic [1:0] fp,
                          input int mode, input bit poke,
                          output int ov_cnt, output int first_cyc, output int last_cyc,
                          output int done_cyc, output int en_cnt);
      int         acc;
      int         emitted;
      int         adv_idx;
      int         stalls;
      int         due[$];
      bit         stream;
      bit         drain;
      bit         fin;
      bit         iv;
      bit         adv;
      bit         exp_ov;
      bit         exp_last;
      logic [8:0] act;
      logic [8:0] exp;
      acc = 0; emitted = 0; adv_idx = 0; stalls = 0; fin = 1'b0;
      ov_cnt = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; en_cnt = 0;
      @(negedge clk);
      bus.start         = 1'b1;
      bus.num_vectors   = 8'(n);
      bus.cfg_data_type = dt;
      bus.cfg_fp_unit   = fp;
      bus.in_valid      = 1'b0;
      #1;
      chk("idle before start", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.done, bus.mxu_enable}), 32'(0));
      for (int cyc = 1; cyc <= 1000 && !fin; cyc++) begin
         @(negedge clk);
         bus.start         = 1'b0;
         bus.num_vectors   = 8'(n);
         bus.cfg_data_type = dt;
         if (poke && cyc == 2) begin
            bus.start         = 1'b1;
            bus.cfg_data_type = ~dt;
            bus.num_vectors   = 8'(n + 3);
         end
         case (mode)
            1:       iv = ($urandom_range(0, 99) < 60);
            2:       iv = !(acc >= 1 && stalls < 3);
            default: iv = 1'b1;
         endcase
         if (mode == 2 && !iv) stalls++;
         bus.in_valid = iv;
         #1;
         stream   = (acc < n);
         drain    = !stream && (emitted < n);
         adv      = stream ? iv : drain;
         exp_ov   = adv && (due.size() > 0) && (due[0] == adv_idx);
         exp_last = exp_ov && (emitted + 1 == n);
         exp = {stream, exp_ov, exp_last, 1'b1, !stream && !drain, {4{adv}}};
         act = {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done,
                bus.mxu_enable, bus.mxu_enable_in_ff, bus.mxu_enable_chain, bus.mxu_enable_out_ff};
         chk("cycle outputs", 32'(act), 32'(exp));
         chk("latched config", 32'({bus.mxu_data_type, bus.mxu_enable_fp_unit}), 32'({dt, fp}));
         if (bus.out_valid) begin
            ov_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
         end
         if (bus.out_last && last_cyc < 0) last_cyc = cyc;
         if (bus.mxu_enable) en_cnt++;
         if (bus.done) done_cyc = cyc;
         if (stream && iv) begin
            due.push_back(adv_idx + LT);
            acc++;
         end
         if (exp_ov) begin
            void'(due.pop_front());
            emitted++;
         end
         if (adv) adv_idx++;
         fin = !stream && !drain;
      end
      if (!fin) chk("job finished within budget", 32'(0), 32'(1));
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
   endtask

   vec_t tbl [7];

   initial begin
      int ov, fc, lc, dc, en;
      int cnt, last_at, nlast, dcyc, rn;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;  bus.num_vectors = '0;  bus.cfg_data_type = '0;  bus.cfg_fp_unit = '0;  bus.in_valid = 1'b0;
      bus4.start = 1'b0; bus4.num_vectors = '0; bus4.cfg_data_type = '0; bus4.cfg_fp_unit = '0; bus4.in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("reset outputs", outs_main(), 32'(0));
      chk("reset outputs cnt4", outs_cnt4(), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;

      //            n    dt     fp     mode poke ov   first last done en
      tbl[0] = '{   4, 2'd1, 2'd2, 0, 1'b0,   4,  6,   9,  10,   9};
      tbl[1] = '{   0, 2'd3, 2'd1, 0, 1'b0,   0, -1,  -1,   1,   0};
      tbl[2] = '{   3, 2'd2, 2'd3, 2, 1'b0,   3,  9,  11,  12,   8};
      tbl[3] = '{   4, 2'd2, 2'd1, 0, 1'b1,   4,  6,   9,  10,   9};
      tbl[4] = '{   1, 2'd0, 2'd0, 0, 1'b0,   1,  6,   6,   7,   6};
      tbl[5] = '{ 255, 2'd1, 2'd3, 0, 1'b0, 255,  6, 260, 261, 260};
      tbl[6] = '{   7, 2'd3, 2'd2, 0, 1'b0,   7,  6,  12,  13,  12};
      for (int i = 0; i < 7; i++) begin
         run_job(tbl[i].n, tbl[i].dt, tbl[i].fp, tbl[i].mode, tbl[i].poke, ov, fc, lc, dc, en);
         chk("table out_valid count", 32'(ov), 32'(tbl[i].exp_ov));
         chk("table first out_valid cycle", 32'(fc), 32'(tbl[i].exp_first));
         chk("table out_last cycle", 32'(lc), 32'(tbl[i].exp_last));
         chk("table done cycle", 32'(dc), 32'(tbl[i].exp_done));
         chk("table enable cycles", 32'(en), 32'(tbl[i].exp_en));
      end

      for (int r = 0; r < 12; r++) begin
         rn = $urandom_range(1, 20);
         run_job(rn, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1, 1'($urandom_range(0, 1)),
                 ov, fc, lc, dc, en);
         chk("random out_valid count", 32'(ov), 32'(rn));
         chk("random enable cycles", 32'(en), 32'(rn + LT));
      end

      // Reset while draining abandons the job; the next job must start clean.
      @(negedge clk);
      bus.start = 1'b1; bus.num_vectors = 8'd5; bus.cfg_data_type = 2'd3; bus.cfg_fp_unit = 2'd3; bus.in_valid = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #1;
      chk("in drain before reset", 32'({bus.busy, bus.in_ready, bus.mxu_enable}), 32'(3'b101));
      rst_n = 1'b0;
      #1;
      chk("outputs during reset", outs_main(), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      run_job(2, 2'd1, 2'd0, 0, 1'b0, ov, fc, lc, dc, en);
      chk("post-reset out_valid count", 32'(ov), 32'(2));
      chk("post-reset done cycle", 32'(dc), 32'(8));

      // Narrow counter at its maximum job length.
      @(negedge clk);
      bus4.start = 1'b1; bus4.num_vectors = 4'd15; bus4.cfg_data_type = 2'd2; bus4.cfg_fp_unit = 2'd1; bus4.in_valid = 1'b1;
      cnt = 0; last_at = -1; nlast = 0; dcyc = -1;
      for (int c = 1; c <= 60 && dcyc < 0; c++) begin
         @(negedge clk);
         bus4.start = 1'b0;
         #1;
         if (bus4.out_valid) cnt++;
         if (bus4.out_last) begin
            nlast++;
            last_at = cnt;
         end
         if (bus4.done) dcyc = c;
      end
      chk("cnt4 out_valid count", 32'(cnt), 32'(15));
      chk("cnt4 out_last index", 32'(last_at), 32'(15));
      chk("cnt4 out_last pulses", 32'(nlast), 32'(1));
      chk("cnt4 done cycle", 32'(dcyc), 32'(21));
      @(negedge clk);
      #1;
      chk("cnt4 idle after job", 32'({bus4.busy, bus4.done, bus4.in_ready}), 32'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
